// File: rtl/imem_loader.sv
// Boot loader that copies an instruction image from a first-word-fall-through FIFO into
// instruction memory, holding the CPU in reset until the whole image has been written.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] num_words,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_w_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_rst_n
);

    localparam logic [ADDR_WIDTH-2:0] MAX_WORDS = (ADDR_WIDTH-1)'(MEM_DEPTH / 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-2:0]   word_cnt_q;
    logic [ADDR_WIDTH-2:0]   word_cnt_d;
    logic [ADDR_WIDTH-2:0]   target_q;
    logic [ADDR_WIDTH-1:0]   mem_wr_addr_q;
    logic [DATA_WIDTH-1:0]   mem_data_in_q;
    logic                    mem_w_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic                    cpu_rst_n_q;
    logic                    last_word;

    // The pop is the only combinational output so a word can leave the FIFO every cycle.
    assign fifo_rd_en = (state_q == LOAD) && !fifo_empty;
    assign word_cnt_d = word_cnt_q + 1'b1;
    assign last_word  = (word_cnt_q == target_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            target_q      <= '0;
            mem_wr_addr_q <= '0;
            mem_data_in_q <= '0;
            mem_w_en_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cpu_rst_n_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    mem_w_en_q <= 1'b0;
                    if (start) begin
                        target_q    <= num_words;
                        word_cnt_q  <= '0;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                        if (num_words == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else if (num_words > MAX_WORDS) begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (fifo_rd_en) begin
                        mem_w_en_q    <= 1'b1;
                        mem_data_in_q <= fifo_data;
                        mem_wr_addr_q <= {word_cnt_q[ADDR_WIDTH-3:0], 2'b00};
                        word_cnt_q    <= word_cnt_d;
                        // The final write is still in flight as the CPU is released.
                        if (last_word) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end
                    end else begin
                        mem_w_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_w_en    = mem_w_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cpu_rst_n   = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a FIFO model feeds the loader and a write log records
// every memory strobe so addresses, data, pop counts and status levels can be checked.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  num_words;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic [9:0]  mem_wr_addr;
    logic [31:0] mem_data_in;
    logic        mem_w_en;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_rst_n;

    logic [31:0] fifoMem [0:1023];
    int          fifoWr = 0;
    int          fifoRd = 0;
    int          popCount = 0;
    logic [9:0]  logAddr [0:1023];
    logic [31:0] logData [0:1023];
    int          logCount = 0;
    int          checks = 0;
    int          fails = 0;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_data_in(mem_data_in),
        .mem_w_en   (mem_w_en),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fifoRd == fifoWr);
    assign fifo_data  = fifoMem[fifoRd[9:0]];

    // FIFO pops and memory captures both happen on the edge after the strobe is seen.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifoRd   <= fifoRd + 1;
            popCount <= popCount + 1;
        end
        if (mem_w_en) begin
            logAddr[logCount[9:0]] <= mem_wr_addr;
            logData[logCount[9:0]] <= mem_data_in;
            logCount <= logCount + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifoMem[fifoWr[9:0]] = w;
        fifoWr = fifoWr + 1;
    endtask

    task automatic pulseStart(input logic [8:0] n);
        start = 1'b1;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int logBase;
        int popBase;
        int cycles;
        logic seqOk;

        rst_n = 1'b0;
        start = 1'b0;
        num_words = '0;
        #2;
        check("rst_w_en", 32'(mem_w_en), 32'd0);
        check("rst_addr", 32'(mem_wr_addr), 32'd0);
        check("rst_data", mem_data_in, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cpu", 32'(cpu_rst_n), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Three-word image loaded back to back.
        push(32'h0000_0013);
        push(32'h0010_0093);
        push(32'h0020_8113);
        logBase = logCount;
        popBase = popCount;
        pulseStart(9'd3);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_cpu_held", 32'(cpu_rst_n), 32'd0);
        check("t1_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        check("t1_w0_en", 32'(mem_w_en), 32'd1);
        check("t1_w0_addr", 32'(mem_wr_addr), 32'h000);
        check("t1_w0_data", mem_data_in, 32'h0000_0013);
        tick();
        check("t1_w1_addr", 32'(mem_wr_addr), 32'h004);
        check("t1_w1_data", mem_data_in, 32'h0010_0093);
        check("t1_w1_done", 32'(done), 32'd0);
        tick();
        check("t1_w2_addr", 32'(mem_wr_addr), 32'h008);
        check("t1_w2_data", mem_data_in, 32'h0020_8113);
        check("t1_w2_en", 32'(mem_w_en), 32'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_rel", 32'(cpu_rst_n), 32'd1);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_rd_off", 32'(fifo_rd_en), 32'd0);
        tick();
        check("t1_w_en_off", 32'(mem_w_en), 32'd0);
        check("t1_hold_addr", 32'(mem_wr_addr), 32'h008);
        check("t1_writes", 32'(logCount - logBase), 32'd3);
        check("t1_pops", 32'(popCount - popBase), 32'd3);
        check("t1_log_addr2", 32'(logAddr[logBase + 2]), 32'h008);

        // Restart from DONE; a start pulse during LOAD must be ignored.
        push(32'hAAAA_0001);
        push(32'hAAAA_0002);
        push(32'hAAAA_0003);
        logBase = logCount;
        popBase = popCount;
        pulseStart(9'd2);
        check("t6_cpu_fall", 32'(cpu_rst_n), 32'd0);
        check("t6_done_fall", 32'(done), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        start = 1'b1;
        num_words = 9'd7;
        tick();
        start = 1'b0;
        check("t6_w0_addr", 32'(mem_wr_addr), 32'h000);
        check("t6_w0_data", mem_data_in, 32'hAAAA_0001);
        tick();
        check("t6_done", 32'(done), 32'd1);
        check("t6_w1_addr", 32'(mem_wr_addr), 32'h004);
        tick();
        check("t6_writes", 32'(logCount - logBase), 32'd2);
        check("t6_pops", 32'(popCount - popBase), 32'd2);
        check("t6_left", 32'(fifoWr - fifoRd), 32'd1);
        fifoWr = fifoRd;

        // Four words with a five-cycle FIFO underrun after the second.
        push(32'hB000_0000);
        push(32'hB000_0001);
        logBase = logCount;
        pulseStart(9'd4);
        tick();
        tick();
        check("t2_w1_addr", 32'(mem_wr_addr), 32'h004);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_gap_w_en", 32'(mem_w_en), 32'd0);
            check("t2_gap_busy", 32'(busy), 32'd1);
        end
        push(32'hB000_0002);
        push(32'hB000_0003);
        tick();
        check("t2_w2_addr", 32'(mem_wr_addr), 32'h008);
        check("t2_w2_data", mem_data_in, 32'hB000_0002);
        tick();
        check("t2_w3_addr", 32'(mem_wr_addr), 32'h00C);
        check("t2_done", 32'(done), 32'd1);
        tick();
        check("t2_writes", 32'(logCount - logBase), 32'd4);
        check("t2_log_addr3", 32'(logAddr[logBase + 3]), 32'h00C);
        check("t2_log_data2", logData[logBase + 2], 32'hB000_0002);

        // Full 256-word image with one extra word queued behind it.
        for (int i = 0; i < 257; i++) push(32'hA000_0000 + 32'(i));
        logBase = logCount;
        popBase = popCount;
        pulseStart(9'd256);
        cycles = 0;
        while (!done && cycles < 400) begin
            tick();
            cycles++;
        end
        check("t3_cycles", 32'(cycles), 32'd256);
        check("t3_last_addr", 32'(mem_wr_addr), 32'h3FC);
        check("t3_last_data", mem_data_in, 32'hA000_00FF);
        tick();
        check("t3_writes", 32'(logCount - logBase), 32'd256);
        check("t3_pops", 32'(popCount - popBase), 32'd256);
        check("t3_left", 32'(fifoWr - fifoRd), 32'd1);
        seqOk = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (logAddr[logBase + i] !== 10'(i * 4)) seqOk = 1'b0;
            if (logData[logBase + i] !== 32'hA000_0000 + 32'(i)) seqOk = 1'b0;
        end
        check("t3_sequence", 32'(seqOk), 32'd1);
        fifoWr = fifoRd;

        // Oversized count goes to ERROR without popping; zero count goes straight to DONE.
        push(32'hDEAD_BEEF);
        logBase = logCount;
        popBase = popCount;
        pulseStart(9'd300);
        check("t4_error", 32'(error), 32'd1);
        check("t4_err_cpu", 32'(cpu_rst_n), 32'd0);
        check("t4_err_done", 32'(done), 32'd0);
        check("t4_err_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        check("t4_err_pops", 32'(popCount - popBase), 32'd0);
        pulseStart(9'd0);
        check("t4_zero_done", 32'(done), 32'd1);
        check("t4_zero_error", 32'(error), 32'd0);
        check("t4_zero_cpu", 32'(cpu_rst_n), 32'd1);
        tick();
        check("t4_writes", 32'(logCount - logBase), 32'd0);
        fifoWr = fifoRd;

        // Reset after two of five words, then reload from address zero.
        for (int i = 0; i < 5; i++) push(32'h5000_0000 + 32'(i));
        pulseStart(9'd5);
        tick();
        tick();
        check("t5_pre_addr", 32'(mem_wr_addr), 32'h004);
        rst_n = 1'b0;
        #1;
        check("t5_rst_w_en", 32'(mem_w_en), 32'd0);
        check("t5_rst_addr", 32'(mem_wr_addr), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_cpu", 32'(cpu_rst_n), 32'd0);
        check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        rst_n = 1'b1;
        push(32'h5000_0005);
        push(32'h5000_0006);
        logBase = logCount;
        pulseStart(9'd5);
        repeat (6) tick();
        check("t5_done", 32'(done), 32'd1);
        check("t5_writes", 32'(logCount - logBase), 32'd5);
        check("t5_first_addr", 32'(logAddr[logBase]), 32'h000);
        check("t5_first_data", logData[logBase], 32'h5000_0002);
        check("t5_last_addr", 32'(logAddr[logBase + 4]), 32'h010);

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
